// File: rtl/ifm_window_buf.sv
// K x K input-feature-map window buffer with full load, LEFT/RIGHT/DOWN sliding,
// valid/ready handshake, a saturating shift counter and a registered 2x2 signed max.
module ifm_window_buf #(
   parameter int DATA_W = 8,
   parameter int K      = 3,
   parameter int LANES  = 4,
   parameter int CNT_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                layer_type,
   input  logic [2:0]                shift_mode,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   ifm_input [K],
   output logic                      win_valid,
   input  logic                      win_ready,
   output logic [DATA_W-1:0]         ifm_output [K*K],
   output logic [DATA_W-1:0]         pool_max,
   output logic [CNT_W-1:0]          shift_cnt
);

   typedef enum logic [1:0] {
      LAYER_NONE  = 2'b00,
      LAYER_CONV  = 2'b01,
      LAYER_POOL  = 2'b10,
      LAYER_FULLY = 2'b11
   } layer_e;

   typedef enum logic [2:0] {
      MODE_RIGHT     = 3'b001,
      MODE_DOWN      = 3'b010,
      MODE_LEFT      = 3'b100,
      MODE_NO_CHANGE = 3'b101,
      MODE_ALL       = 3'b111
   } mode_e;

   logic signed [DATA_W-1:0] win_q [K][K];
   logic signed [DATA_W-1:0] win_d [K][K];
   logic signed [DATA_W-1:0] pool_d;
   logic                     accept;
   logic                     cnt_inc;
   logic                     cnt_clr;
   logic                     unused_bits;

   function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   assign in_ready = (layer_type != LAYER_NONE) && (!win_valid || win_ready);
   assign accept   = in_valid && in_ready;

   // Candidate next window; only committed on accept. FULLY allows only full loads.
   always_comb begin
      win_d   = win_q;
      cnt_inc = 1'b0;
      cnt_clr = 1'b0;
      case (shift_mode)
         MODE_ALL: begin
            cnt_clr = 1'b1;
            for (int r = 0; r < K; r++)
               for (int c = 0; c < K; c++)
                  win_d[r][c] = ifm_input[r][(K-1-c)*DATA_W +: DATA_W];
         end
         MODE_RIGHT: begin
            if (layer_type != LAYER_FULLY) begin
               cnt_inc = 1'b1;
               for (int r = 0; r < K; r++) begin
                  for (int c = 0; c < K-1; c++)
                     win_d[r][c] = win_q[r][c+1];
                  win_d[r][K-1] = ifm_input[r][DATA_W-1:0];
               end
            end
         end
         MODE_LEFT: begin
            if (layer_type != LAYER_FULLY) begin
               cnt_inc = 1'b1;
               for (int r = 0; r < K; r++) begin
                  for (int c = K-1; c > 0; c--)
                     win_d[r][c] = win_q[r][c-1];
                  win_d[r][0] = ifm_input[r][DATA_W-1:0];
               end
            end
         end
         MODE_DOWN: begin
            if (layer_type != LAYER_FULLY) begin
               cnt_inc = 1'b1;
               for (int r = 0; r < K-1; r++)
                  win_d[r] = win_q[r+1];
               for (int c = 0; c < K; c++)
                  win_d[K-1][c] = ifm_input[0][(K-1-c)*DATA_W +: DATA_W];
            end
         end
         default: ;
      endcase
      pool_d = smax(smax(win_d[0][0], win_d[0][1]), smax(win_d[1][0], win_d[1][1]));
   end

   // Pad lanes above the window width and unused rows feed nothing.
   always_comb begin
      unused_bits = 1'b0;
      for (int r = 0; r < K; r++)
         unused_bits = unused_bits ^ (^ifm_input[r]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q     <= '{default: '0};
         pool_max  <= '0;
         shift_cnt <= '0;
         win_valid <= 1'b0;
      end else begin
         if (accept) begin
            win_q    <= win_d;
            pool_max <= pool_d;
            if (cnt_clr)
               shift_cnt <= '0;
            else if (cnt_inc && (shift_cnt != '1))
               shift_cnt <= shift_cnt + CNT_W'(1);
         end
         if (accept)
            win_valid <= 1'b1;
         else if (win_ready || (layer_type == LAYER_NONE))
            win_valid <= 1'b0;
      end
   end

   always_comb begin
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            ifm_output[r*K+c] = win_q[r][c];
   end

endmodule

// File: doc/ifm_window_buf.md
# ifm_window_buf

Parametrised input-feature-map window buffer that feeds the K×K PE array. It assembles a K×K pixel window from K packed input words, one per window row, and updates it by full load or by single-column/row sliding. It presents the window with a valid/ready handshake and a registered 2×2 max for pooling layers. It sits between the IFM SRAM read path and the PE array / pooling unit. It supersedes the fixed 3×3, 32-bit buffer by adding back-pressure, LEFT/DOWN sliding and a shift counter.

## Interface
- DATA_W, 8: pixel width, signed two's complement
- K, 3: window side; PE array size is K*K; requires 2 ≤ K ≤ LANES
- LANES, 4: pixels packed per input word; word width = LANES*DATA_W
- CNT_W, 8: shift counter width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- layer_type  in  2  01 CONVOLUTION, 10 POOLING, 11 FULLY, 00 NONE
- shift_mode  in  3  111 ALL, 001 RIGHT, 010 DOWN, 100 LEFT, 101 NO_CHANGE
- in_valid  in  1  ifm_input and shift_mode valid this cycle
- in_ready  out  1  buffer accepts input this cycle
- ifm_input  in  K × LANES*DATA_W  packed row words; row r in element r
- win_valid  out  1  window/pool outputs valid
- win_ready  in  1  consumer accepts window
- ifm_output  out  K*K × DATA_W  window, element r*K+c = W[r][c]
- pool_max  out  DATA_W  signed max of W[0][0], W[0][1], W[1][0], W[1][1]
- shift_cnt  out  CNT_W  accepted slide operations since last ALL

## Operation
- Byte b of a word is bits [b*DATA_W +: DATA_W]. Pixel column c of a full row is byte K-1-c, so the most significant used byte is leftmost.
- An accept (in_valid && in_ready) applies shift_mode to the window W:
  - ALL: W[r][c] ← ifm_input[r].byte[K-1-c] for all r, c. shift_cnt ← 0.
  - RIGHT: W[r][c] ← W[r][c+1] for c<K-1. W[r][K-1] ← ifm_input[r].byte[0].
  - LEFT: W[r][c] ← W[r][c-1] for c>0. W[r][0] ← ifm_input[r].byte[0].
  - DOWN: W[r] ← W[r+1] for r<K-1. W[K-1][c] ← ifm_input[0].byte[K-1-c]. Rows 1..K-1 of ifm_input are ignored.
  - NO_CHANGE, and every other code: W unchanged, window re-emitted.
- RIGHT, LEFT and DOWN increment shift_cnt, saturating at 2^CNT_W-1. NO_CHANGE does not change shift_cnt.
- layer_type behaviour:
  - FULLY: only ALL updates W. Any other mode behaves as NO_CHANGE and does not increment shift_cnt.
  - POOLING and CONVOLUTION: identical window behaviour. pool_max is always computed; consumers ignore it in CONVOLUTION.
  - NONE: in_ready = 0. win_valid clears on the next edge regardless of win_ready. W, pool_max and shift_cnt hold.
- pool_max is registered. It is computed from the next-state W on the same edge that updates W, so it is aligned with ifm_output. Signed compare: 'h80 (-128) < 'h7F.
- Reset: W all 0, pool_max 0, shift_cnt 0, win_valid 0. in_ready is combinational and equals 1 while layer_type ≠ NONE.

## Timing
- in_ready = (layer_type ≠ NONE) && (!win_valid || win_ready). It is combinational and has no dependence on in_valid.
- Latency is 1 cycle: an accept at edge n makes the updated window visible with win_valid=1 after edge n.
- win_valid next state:
  - 1 on accept.
  - Else 0 if win_ready or layer_type = NONE.
  - Else holds.
- Accept and win_ready in the same cycle: the old window is consumed and the new window is loaded. No bubble, full throughput of 1 window/cycle.
- While win_valid && !win_ready: ifm_output, pool_max and shift_cnt are stable and no input is accepted.
- shift_mode and layer_type are sampled only on accept. The exception is the NONE gating of in_ready and win_valid.
- rst_n assertion mid-stream clears all state asynchronously, including a pending window. win_valid is 0 from the first cycle after deassertion.

## Test plan
- Full load, K=3, CONVOLUTION:
  - Stimulus: ifm_input = {'h00010203, 'h00040506, 'h00070809}, ALL, win_ready=1.
  - Required response: one cycle later win_valid=1, ifm_output = 1..9 in order, pool_max=5, shift_cnt=0.
- Right slide after the full load:
  - Stimulus: ifm_input = {'h0A, 'h0B, 'h0C}, RIGHT.
  - Required response: rows {2,3,A}, {5,6,B}, {8,9,C}; shift_cnt=1.
  - Then LEFT with {'h01, 'h04, 'h07}: rows restored to 1..9, shift_cnt=2.
- Down slide:
  - Stimulus: after a full load, DOWN with ifm_input[0] = 'h000D0E0F.
  - Required response: rows {4,5,6}, {7,8,9}, {D,E,F}.
- Back-pressure:
  - Stimulus: hold win_ready=0 after the first window, keep in_valid=1 with RIGHT for 5 cycles.
  - Required response: in_ready=0, outputs frozen, shift_cnt unchanged. Raising win_ready gives exactly one accept per cycle thereafter.
- Pooling signed max:
  - Stimulus: POOLING, ALL with top-left 2×2 = {'h80, 'hF0, 'h05, 'h7F}.
  - Required response: pool_max='h7F.
  - With {'h80, 'hF0, 'hFF, 'h90}: pool_max='hFF.
- Mode and reset edge cases:
  - FULLY with RIGHT: window unchanged, shift_cnt unchanged.
  - 260 RIGHT accepts: shift_cnt saturates at 255.
  - layer_type=NONE: win_valid drops next edge.
  - rst_n pulsed mid-stream: all outputs 0 and win_valid=0.
